// File: rtl/mem_request_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_request_unit_pkg
// Brief    : Shared types and helpers for the memory request unit.
// Revision : 1.0 - initial release
// ============================================================================
package mem_request_unit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DREQ   = 2'd2,
        HALTED = 2'd3
    } reqstate_t;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } memop_t;

    // Counter width able to hold 0..limit, never narrower than one bit.
    function automatic int unsigned ctr_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_request_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_request_unit_if
// Brief    : Core-side / memory-side signal bundle of the memory request unit.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_request_unit_if #(
    parameter int unsigned WORD_W = 32
);
    logic              ihit;
    logic              dhit;
    logic              halt;
    logic              dren_in;
    logic              dwen_in;
    logic [WORD_W-1:0] daddr_in;
    logic [WORD_W-1:0] dstore_in;
    logic              imemREN;
    logic              dmemREN;
    logic              dmemWEN;
    logic [WORD_W-1:0] dmemaddr;
    logic [WORD_W-1:0] dmemstore;
    logic              pc_en;
    logic              busy;
    logic              timeout_err;

    modport master (
        input  ihit, dhit, halt, dren_in, dwen_in, daddr_in, dstore_in,
        output imemREN, dmemREN, dmemWEN, dmemaddr, dmemstore, pc_en, busy, timeout_err
    );

    modport slave (
        output ihit, dhit, halt, dren_in, dwen_in, daddr_in, dstore_in,
        input  imemREN, dmemREN, dmemWEN, dmemaddr, dmemstore, pc_en, busy, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_request_unit_timeout.sv
`default_nettype none
// ============================================================================
// Module   : mem_request_unit_timeout
// Brief    : Saturating stall counter with a sticky over-limit flag.
// Revision : 1.0 - initial release
// ============================================================================
module mem_request_unit_timeout
    import mem_request_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic CLK,
    input  logic nRST,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_timeout_err
);

    generate
        if (TIMEOUT_CYC == 0) begin : g_disabled
            wire w_unused_ctl = &{1'b0, CLK, nRST, i_clear, i_enable};
            assign o_timeout_err = 1'b0;
        end else begin : g_enabled
            localparam int unsigned             c_cnt_w = ctr_width(TIMEOUT_CYC);
            localparam logic [c_cnt_w-1:0]      c_limit = c_cnt_w'(TIMEOUT_CYC);

            logic [c_cnt_w-1:0] r_count;
            logic               r_err;

            // The flag is set on the edge that brings the count to the limit.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    r_count <= '0;
                    r_err   <= 1'b0;
                end else if (i_clear) begin
                    r_count <= '0;
                end else if (i_enable) begin
                    if (r_count != c_limit) begin
                        r_count <= r_count + 1'b1;
                    end
                    if (r_count == c_limit - 1'b1) begin
                        r_err <= 1'b1;
                    end
                end
            end

            assign o_timeout_err = r_err;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_request_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_request_unit
// Brief    : Sequences instruction fetch and data load/store requests.
// Revision : 1.0 - initial release
// ============================================================================
module mem_request_unit
    import mem_request_unit_pkg::*;
#(
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter bit          HOLD_ADDR   = 1'b1
) (
    input  logic               CLK,
    input  logic               nRST,
    mem_request_unit_if.master ruif
);

    reqstate_t         r_state;
    reqstate_t         w_next_state;
    memop_t            r_op;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_store;
    logic              w_is_mem;
    logic              w_capture;
    logic              w_stall;

    assign w_is_mem  = ruif.dren_in | ruif.dwen_in;
    assign w_capture = (r_state == FETCH) & ruif.ihit & ~ruif.halt & w_is_mem;
    assign w_stall   = (r_state == DREQ) & ~ruif.dhit;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = FETCH;
            FETCH: begin
                if (ruif.ihit) begin
                    if (ruif.halt) begin
                        w_next_state = HALTED;
                    end else if (w_is_mem) begin
                        w_next_state = DREQ;
                    end
                end
            end
            DREQ: begin
                if (ruif.dhit) begin
                    w_next_state = FETCH;
                end
            end
            HALTED:  w_next_state = HALTED;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        ruif.imemREN = 1'b0;
        ruif.dmemREN = 1'b0;
        ruif.dmemWEN = 1'b0;
        ruif.pc_en   = 1'b0;
        ruif.busy    = 1'b0;
        case (r_state)
            FETCH: begin
                ruif.imemREN = 1'b1;
                ruif.pc_en   = ruif.ihit & ~ruif.halt & ~w_is_mem;
            end
            DREQ: begin
                ruif.dmemREN = (r_op == OP_LOAD);
                ruif.dmemWEN = (r_op == OP_STORE);
                ruif.busy    = 1'b1;
                ruif.pc_en   = ruif.dhit;
            end
            default: ;
        endcase
    end

    // A store request takes priority when both load and store are decoded.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_op    <= OP_LOAD;
            r_addr  <= '0;
            r_store <= '0;
        end else if (w_capture) begin
            r_op    <= ruif.dwen_in ? OP_STORE : OP_LOAD;
            r_addr  <= ruif.daddr_in;
            r_store <= ruif.dstore_in;
        end
    end

    generate
        if (HOLD_ADDR) begin : g_hold
            assign ruif.dmemaddr  = r_addr;
            assign ruif.dmemstore = r_store;
        end else begin : g_pass
            wire w_unused_latch = ^{r_addr, r_store};
            assign ruif.dmemaddr  = ruif.daddr_in;
            assign ruif.dmemstore = ruif.dstore_in;
        end
    endgenerate

    mem_request_unit_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .CLK           (CLK),
        .nRST          (nRST),
        .i_clear       (w_capture),
        .i_enable      (w_stall),
        .o_timeout_err (ruif.timeout_err)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_request_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_request_unit
// Brief    : Randomised scoreboard bench for mem_request_unit.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_request_unit;

    localparam int c_tmo = 4;

    localparam int P_IDLE  = 0;
    localparam int P_INSTR = 1;
    localparam int P_DATA  = 2;
    localparam int P_STOP  = 3;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    mem_request_unit_if #(.WORD_W(32)) bus ();

    mem_request_unit #(
        .WORD_W      (32),
        .TIMEOUT_CYC (c_tmo),
        .HOLD_ADDR   (1'b1)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .ruif (bus)
    );

    always #5 CLK = ~CLK;

    int   checks   = 0;
    int   failures = 0;
    acc_t exp_q[$];

    // Transaction-level model: what the core is waiting for right now.
    int       m_phase    = P_IDLE;
    int       m_wait     = 0;
    int       m_lat      = 1;
    bit       m_tmo      = 1'b0;
    acc_t     m_cur      = '0;
    int       max_lat    = 4;
    bit       allow_halt = 1'b0;
    // {imemREN, dmemREN, dmemWEN, pc_en, busy, timeout_err}
    logic [5:0] exp_ctrl = '0;

    bit   mon_en   = 1'b0;
    bit   mon_prev = 1'b0;
    acc_t mon_cur  = '0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge CLK);
            if (!mon_en) begin
                mon_prev = 1'b0;
            end else begin
                chk("ctrl", 96'({bus.imemREN, bus.dmemREN, bus.dmemWEN,
                                 bus.pc_en, bus.busy, bus.timeout_err}), 96'(exp_ctrl));
                if (bus.dmemREN | bus.dmemWEN) begin
                    if (!mon_prev) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL access_unexpected actual=request required=none");
                        end else begin
                            mon_cur = exp_q.pop_front();
                        end
                    end
                    chk("access", 96'({bus.dmemWEN, bus.dmemaddr, bus.dmemstore}), 96'(mon_cur));
                end
                mon_prev = bus.dmemREN | bus.dmemWEN;
            end
        end
    end

    task automatic drive(input logic ih, dh, h, r, w, input logic [31:0] a, d);
        bus.ihit      = ih;
        bus.dhit      = dh;
        bus.halt      = h;
        bus.dren_in   = r;
        bus.dwen_in   = w;
        bus.daddr_in  = a;
        bus.dstore_in = d;
    endtask

    // One cycle: entered and left at 1ns after the rising edge.
    task automatic step();
        logic        hit_i, hit_d, h, r, w;
        logic [31:0] a, d;
        hit_i = 1'($urandom_range(0, 1));
        hit_d = 1'($urandom_range(0, 1));
        h     = 1'($urandom_range(0, 1));
        r     = 1'($urandom_range(0, 1));
        w     = 1'($urandom_range(0, 1));
        a     = $urandom;
        d     = $urandom;
        exp_ctrl = {5'b0, m_tmo};
        case (m_phase)
            P_INSTR: begin
                hit_i       = ($urandom_range(0, 3) != 0);
                h           = allow_halt && ($urandom_range(0, 5) == 0);
                exp_ctrl[5] = 1'b1;
                exp_ctrl[2] = hit_i & ~h & ~r & ~w;
            end
            P_DATA: begin
                hit_d       = (m_wait + 1 == m_lat);
                exp_ctrl[4] = ~m_cur.wr;
                exp_ctrl[3] = m_cur.wr;
                exp_ctrl[2] = hit_d;
                exp_ctrl[1] = 1'b1;
            end
            default: ;
        endcase
        drive(hit_i, hit_d, h, r, w, a, d);
        @(posedge CLK);
        #1;
        case (m_phase)
            P_IDLE:  m_phase = P_INSTR;
            P_INSTR: begin
                if (hit_i) begin
                    if (h) begin
                        m_phase = P_STOP;
                    end else if (r | w) begin
                        m_cur   = '{wr: w, addr: a, data: d};
                        exp_q.push_back(m_cur);
                        m_wait  = 0;
                        m_lat   = $urandom_range(1, max_lat);
                        m_phase = P_DATA;
                    end
                end
            end
            P_DATA: begin
                if (hit_d) begin
                    m_phase = P_INSTR;
                end else begin
                    m_wait++;
                    if (m_wait >= c_tmo) m_tmo = 1'b1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        nRST   = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_outputs", 96'({bus.imemREN, bus.dmemREN, bus.dmemWEN, bus.pc_en, bus.busy,
                                  bus.timeout_err, bus.dmemaddr, bus.dmemstore}), 96'(0));
        nRST    = 1'b1;
        m_phase = P_IDLE;
        m_tmo   = 1'b0;
        m_wait  = 0;
        exp_q.delete();
        mon_en  = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin : stimulus
        int n;
        do_reset();

        max_lat = c_tmo;
        repeat (400) step();

        max_lat = 2 * c_tmo;
        repeat (300) step();

        // Pull reset while a data access is outstanding.
        n = 0;
        while (m_phase != P_DATA && n < 200) begin
            step();
            n++;
        end
        chk("reach_data", 96'(m_phase), 96'(P_DATA));
        mon_en = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("pre_reset_req", 96'({bus.dmemREN, bus.dmemWEN}), 96'({~m_cur.wr, m_cur.wr}));
        #2;
        nRST = 1'b0;
        #1;
        chk("async_drop", 96'({bus.imemREN, bus.dmemREN, bus.dmemWEN, bus.busy,
                               bus.pc_en, bus.timeout_err}), 96'(0));
        @(posedge CLK);
        #1;
        nRST    = 1'b1;
        m_phase = P_IDLE;
        m_tmo   = 1'b0;
        m_wait  = 0;
        exp_q.delete();
        mon_en  = 1'b1;
        repeat (100) step();

        allow_halt = 1'b1;
        n = 0;
        while (m_phase != P_STOP && n < 2000) begin
            step();
            n++;
        end
        chk("reach_halt", 96'(m_phase), 96'(P_STOP));
        repeat (25) step();
        chk("queue_drained", 96'(exp_q.size()), 96'(0));

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
